// File: rtl/alu_cmd_seq.sv
// Command sequencer around an external registered 64-bit ALU: 8x64 register file,
// three-state issue/capture FSM, writeback, response and sticky-overflow tracking.
module alu_cmd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_rs1,
    input  logic [2:0]  cmd_rs2,
    input  logic        cmd_use_imm,
    input  logic [63:0] cmd_imm,
    input  logic        host_we,
    input  logic [2:0]  host_waddr,
    input  logic [63:0] host_wdata,
    input  logic [2:0]  host_raddr,
    output logic [63:0] host_rdata,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [63:0] alu_cmp_val,
    output logic [3:0]  alu_ctrl,
    input  logic [63:0] alu_z,
    input  logic        alu_ovf,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic [2:0]  rsp_rd,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic        ovf_sticky,
    input  logic        ovf_clr
);

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_SHL_CMP = 4'b1001;
    localparam logic [3:0] OP_SHR_CMP = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] regs [8];
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] b_sel;
    logic        is_shift_cmp;
    logic        accept;
    logic        wb_en;

    logic [3:0]  op_q;
    logic [2:0]  rd_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic [63:0] cmp_q;
    logic        op_bad;

    // Register reads see contents from before any write at the same edge.
    always_comb begin
        rs1_val    = (cmd_rs1 == 3'd0) ? '0 : regs[cmd_rs1];
        rs2_val    = (cmd_rs2 == 3'd0) ? '0 : regs[cmd_rs2];
        host_rdata = (host_raddr == 3'd0) ? '0 : regs[host_raddr];
    end

    // Shift-compare ops need rs2 as shift amount, so imm is only the compare value.
    always_comb begin
        is_shift_cmp = (cmd_op == OP_SHL_CMP) || (cmd_op == OP_SHR_CMP);
        b_sel        = (cmd_use_imm && !is_shift_cmp) ? cmd_imm : rs2_val;
        accept       = cmd_valid && cmd_ready;
        op_bad       = (op_q > OP_SHR_CMP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            rd_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cmp_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q  <= cmd_op;
                rd_q  <= cmd_rd;
                a_q   <= rs1_val;
                b_q   <= b_sel;
                cmp_q <= cmd_imm;
            end
        end
    end

    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_cmp_val = '0;
        alu_ctrl    = '0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_rd      = '0;
        rsp_ovf     = 1'b0;
        rsp_err     = 1'b0;
        wb_en       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next  = CAPTURE;
                alu_a       = a_q;
                alu_b       = b_q;
                alu_cmp_val = cmp_q;
                alu_ctrl    = op_q;
            end
            CAPTURE: begin
                state_next  = IDLE;
                alu_a       = a_q;
                alu_b       = b_q;
                alu_cmp_val = cmp_q;
                alu_ctrl    = op_q;
                rsp_valid   = 1'b1;
                rsp_rd      = rd_q;
                rsp_err     = op_bad;
                rsp_data    = op_bad ? '0 : alu_z;
                rsp_ovf     = ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_ovf;
                wb_en       = !op_bad && (rd_q != 3'd0);
            end
            default: state_next = IDLE;
        endcase
    end

    // Writeback is assigned after the host port so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i[2:0]] <= '0;
            end
        end else begin
            if (host_we && (host_waddr != 3'd0)) begin
                regs[host_waddr] <= host_wdata;
            end
            if (wb_en) begin
                regs[rd_q] <= rsp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (rsp_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq: a stand-in registered ALU, a vector table for
// single commands, and hand-written sequences for multi-cycle corner cases.
module tb_alu_cmd_seq;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic        cmd_use_imm;
    logic [63:0] cmd_imm;
    logic        host_we;
    logic [2:0]  host_waddr;
    logic [63:0] host_wdata;
    logic [2:0]  host_raddr;
    logic [63:0] host_rdata;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_cmp_val;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_z;
    logic        alu_ovf;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic [2:0]  rsp_rd;
    logic        rsp_ovf;
    logic        rsp_err;
    logic        ovf_sticky;
    logic        ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
        .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_raddr(host_raddr), .host_rdata(host_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmp_val(alu_cmp_val), .alu_ctrl(alu_ctrl),
        .alu_z(alu_z), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: result one cycle after operands. Overflow is meaningless for
    // non-arithmetic ops, so it is driven high there to expose any leak.
    logic [63:0] m_sum;
    logic [63:0] m_dif;
    always_comb begin
        m_sum = alu_a + alu_b;
        m_dif = alu_a - alu_b;
    end
    always_ff @(posedge clk) begin
        case (alu_ctrl)
            4'b0000: begin
                alu_z   <= m_sum;
                alu_ovf <= (alu_a[63] == alu_b[63]) && (m_sum[63] != alu_a[63]);
            end
            4'b0001: begin
                alu_z   <= m_dif;
                alu_ovf <= (alu_a[63] != alu_b[63]) && (m_dif[63] != alu_a[63]);
            end
            4'b1001: begin
                alu_z   <= {63'd0, (alu_a << alu_b[5:0]) == alu_cmp_val};
                alu_ovf <= 1'b1;
            end
            4'b1010: begin
                alu_z   <= {63'd0, (alu_a >> alu_b[5:0]) == alu_cmp_val};
                alu_ovf <= 1'b1;
            end
            default: begin
                alu_z   <= alu_a ^ alu_b;
                alu_ovf <= 1'b1;
            end
        endcase
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached, got hang required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        use_imm;
        logic [63:0] imm;
        logic [63:0] pre_rd;
        logic [63:0] pre1;
        logic [63:0] pre2;
        logic [63:0] exp_b;
        logic [63:0] exp_data;
        logic        exp_ovf;
        logic        exp_err;
        logic [63:0] exp_reg;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic wr(input logic [2:0] a, input logic [63:0] d);
        host_we = 1'b1; host_waddr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [2:0] a, input logic [63:0] exp);
        host_raddr = a;
        #1;
        chk(name, host_rdata, exp);
    endtask

    task automatic start_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic use_imm, input logic [63:0] imm);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_use_imm = use_imm; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        logic [63:0] d;
        logic [2:0]  r;
        logic        o;
        logic        e;
        if (v.rd != 3'd0) wr(v.rd, v.pre_rd);
        wr(v.rs1, v.pre1);
        wr(v.rs2, v.pre2);
        chk($sformatf("v%0d ready", idx), cmd_ready, 1);
        start_cmd(v.op, v.rd, v.rs1, v.rs2, v.use_imm, v.imm);
        lat = 0; d = '0; r = '0; o = 1'b0; e = 1'b0;
        for (int k = 1; k <= 4 && lat == 0; k++) begin
            if (k == 1) begin
                chk($sformatf("v%0d alu_ctrl", idx), alu_ctrl, v.op);
                chk($sformatf("v%0d alu_a", idx), alu_a, v.pre1);
                chk($sformatf("v%0d alu_b", idx), alu_b, v.exp_b);
                chk($sformatf("v%0d alu_cmp_val", idx), alu_cmp_val, v.imm);
            end
            if (rsp_valid) begin
                lat = k; d = rsp_data; r = rsp_rd; o = rsp_ovf; e = rsp_err;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d latency", idx), lat, 2);
        chk($sformatf("v%0d rsp_data", idx), d, v.exp_data);
        chk($sformatf("v%0d rsp_rd", idx), r, v.rd);
        chk($sformatf("v%0d rsp_ovf", idx), o, v.exp_ovf);
        chk($sformatf("v%0d rsp_err", idx), e, v.exp_err);
        chk($sformatf("v%0d idle alu_a", idx), alu_a, 0);
        chk($sformatf("v%0d idle rsp_valid", idx), rsp_valid, 0);
        rdchk($sformatf("v%0d reg rd", idx), v.rd, v.exp_reg);
    endtask

    initial begin
        logic [8:0] acc;
        int         expd;

        //          op     rd    rs1   rs2   imm? imm          pre_rd        pre1                   pre2         exp_b        exp_data               ovf   err   exp_reg
        vecs[0]  = '{4'h0, 3'd3, 3'd1, 3'd2, 1'b0, 64'h0,      64'h0,        64'd5,                 64'd7,       64'd7,       64'd12,                1'b0, 1'b0, 64'd12};
        vecs[1]  = '{4'h0, 3'd4, 3'd1, 3'd2, 1'b0, 64'h0,      64'h0,        64'h7FFF_FFFF_FFFF_FFFF, 64'd1,     64'd1,       64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'h8000_0000_0000_0000};
        vecs[2]  = '{4'h9, 3'd5, 3'd1, 3'd2, 1'b1, 64'hF0,     64'h0,        64'h0F,                64'd4,       64'd4,       64'd1,                 1'b0, 1'b0, 64'd1};
        vecs[3]  = '{4'h9, 3'd5, 3'd1, 3'd2, 1'b1, 64'hF1,     64'h99,       64'h0F,                64'd4,       64'd4,       64'd0,                 1'b0, 1'b0, 64'd0};
        vecs[4]  = '{4'hA, 3'd6, 3'd1, 3'd2, 1'b0, 64'h0F,     64'h77,       64'hF0,                64'd4,       64'd4,       64'd1,                 1'b0, 1'b0, 64'd1};
        vecs[5]  = '{4'h1, 3'd6, 3'd1, 3'd2, 1'b0, 64'h0,      64'h0,        64'd10,                64'd3,       64'd3,       64'd7,                 1'b0, 1'b0, 64'd7};
        vecs[6]  = '{4'h1, 3'd7, 3'd1, 3'd2, 1'b0, 64'h0,      64'h0,        64'h8000_0000_0000_0000, 64'd1,     64'd1,       64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[7]  = '{4'h0, 3'd7, 3'd1, 3'd2, 1'b1, 64'd23,     64'h0,        64'd100,               64'd999,     64'd23,      64'd123,               1'b0, 1'b0, 64'd123};
        vecs[8]  = '{4'hF, 3'd2, 3'd1, 3'd2, 1'b0, 64'h1234,   64'h0,        64'h33,                64'h55,      64'h55,      64'd0,                 1'b0, 1'b1, 64'h55};
        vecs[9]  = '{4'h0, 3'd0, 3'd1, 3'd2, 1'b0, 64'h0,      64'h0,        64'd5,                 64'd7,       64'd7,       64'd12,                1'b0, 1'b0, 64'd0};
        vecs[10] = '{4'hB, 3'd3, 3'd1, 3'd2, 1'b1, 64'h40,     64'hAB,       64'd1,                 64'd2,       64'h40,      64'd0,                 1'b0, 1'b1, 64'hAB};
        vecs[11] = '{4'hA, 3'd5, 3'd1, 3'd2, 1'b0, 64'd1,      64'h0,        64'h8000_0000_0000_0000, 64'd63,    64'd63,      64'd1,                 1'b0, 1'b0, 64'd1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_use_imm = 1'b0; cmd_imm = '0; host_we = 1'b0; host_waddr = '0; host_wdata = '0;
        host_raddr = '0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset alu_a", alu_a, 0);
        chk("reset ovf_sticky", ovf_sticky, 0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) rdchk($sformatf("reset reg%0d", i), 3'(i), 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
        chk("sticky after overflows", ovf_sticky, 1);

        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("sticky cleared", ovf_sticky, 0);
        run_vec(vecs[2], 2);
        chk("sticky not set by compare op", ovf_sticky, 0);

        // Set and clear on the same edge: set wins, then clear takes effect.
        wr(3'd1, 64'h7FFF_FFFF_FFFF_FFFF);
        wr(3'd2, 64'd1);
        start_cmd(4'h0, 3'd4, 3'd1, 3'd2, 1'b0, 64'h0);
        ovf_clr = 1'b1;
        @(negedge clk);
        chk("sticky before capture edge", ovf_sticky, 0);
        @(negedge clk);
        chk("sticky set wins over clr", ovf_sticky, 1);
        @(negedge clk);
        chk("sticky cleared after set", ovf_sticky, 0);
        ovf_clr = 1'b0;

        // Back-to-back dependent increments with cmd_valid held high.
        wr(3'd1, 64'd1);
        cmd_valid = 1'b1; cmd_op = 4'h0; cmd_rd = 3'd1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd0;
        cmd_use_imm = 1'b1; cmd_imm = 64'd1;
        acc = '0; expd = 2;
        for (int c = 0; c < 9; c++) begin
            if (cmd_ready) acc[c] = 1'b1;
            if (rsp_valid) begin
                chk($sformatf("b2b rsp_data cycle %0d", c), rsp_data, 64'(expd));
                expd++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("b2b accept cycles", acc, 9'b001_001_001);
        chk("b2b response count", expd - 2, 3);
        rdchk("b2b final r1", 3'd1, 64'd4);

        // Command inputs ignored while busy; host write to rd loses to writeback.
        wr(3'd1, 64'd5);
        wr(3'd2, 64'd7);
        wr(3'd3, 64'h11);
        wr(3'd6, 64'h66);
        start_cmd(4'h0, 3'd3, 3'd1, 3'd2, 1'b0, 64'h0);
        cmd_valid = 1'b1; cmd_op = 4'h1; cmd_rs1 = 3'd6; cmd_rd = 3'd6;
        @(negedge clk);
        chk("busy ignore rsp_valid", rsp_valid, 1);
        chk("busy ignore alu_ctrl", alu_ctrl, 4'h0);
        chk("busy ignore alu_a", alu_a, 64'd5);
        cmd_valid = 1'b0;
        host_we = 1'b1; host_waddr = 3'd3; host_wdata = 64'hDEAD;
        @(negedge clk);
        host_we = 1'b0;
        rdchk("collision same addr", 3'd3, 64'd12);
        rdchk("busy ignore r6", 3'd6, 64'h66);

        start_cmd(4'h0, 3'd4, 3'd1, 3'd2, 1'b0, 64'h0);
        @(negedge clk);
        host_we = 1'b1; host_waddr = 3'd6; host_wdata = 64'h600;
        @(negedge clk);
        host_we = 1'b0;
        rdchk("collision diff addr rd", 3'd4, 64'd12);
        rdchk("collision diff addr host", 3'd6, 64'h600);

        // Host read has no write bypass.
        wr(3'd5, 64'h5A5A);
        host_raddr = 3'd5; host_we = 1'b1; host_waddr = 3'd5; host_wdata = 64'hBEEF;
        #1;
        chk("no bypass old value", host_rdata, 64'h5A5A);
        @(negedge clk);
        host_we = 1'b0;
        #1;
        chk("no bypass new value", host_rdata, 64'hBEEF);

        // Reset during ISSUE aborts the command and beats a host write.
        run_vec(vecs[1], 1);
        chk("sticky before abort", ovf_sticky, 1);
        wr(3'd1, 64'd5);
        wr(3'd2, 64'd7);
        start_cmd(4'h0, 3'd3, 3'd1, 3'd2, 1'b0, 64'h0);
        reset = 1'b1; host_we = 1'b1; host_waddr = 3'd6; host_wdata = 64'h999;
        @(negedge clk);
        chk("abort rsp_valid in reset", rsp_valid, 0);
        reset = 1'b0; host_we = 1'b0;
        chk("abort cmd_ready", cmd_ready, 1);
        chk("abort sticky", ovf_sticky, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort no rsp %0d", c), rsp_valid, 0);
        end
        for (int i = 0; i < 8; i++) rdchk($sformatf("abort reg%0d", i), 3'(i), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
